// File: rtl/hdlc_tx_if.sv
// Frame-side bus of the HDLC transmit framer: byte handshake, frame control and serial/status outputs.
// The Tx buffer drives through the master modport; the framer uses the slave modport.
interface hdlc_tx_if;
  logic       Tx_Start;
  logic [7:0] Tx_Data;
  logic       Tx_DataValid;
  logic       Tx_Last;
  logic       Tx_DataReady;
  logic       Tx_AbortFrame;
  logic       Tx;
  logic       Tx_Busy;
  logic       Tx_Done;
  logic       Tx_AbortedTrans;
  logic       Tx_Underrun;

  modport master (
    output Tx_Start, Tx_Data, Tx_DataValid, Tx_Last, Tx_AbortFrame,
    input  Tx_DataReady, Tx, Tx_Busy, Tx_Done, Tx_AbortedTrans, Tx_Underrun
  );

  modport slave (
    input  Tx_Start, Tx_Data, Tx_DataValid, Tx_Last, Tx_AbortFrame,
    output Tx_DataReady, Tx, Tx_Busy, Tx_Done, Tx_AbortedTrans, Tx_Underrun
  );
endinterface

// File: rtl/hdlc_tx_framer.sv
// Bit-level HDLC transmit framer: flags, zero insertion, abort sequence and one-byte prefetch.
// Define HDLC_TX_FCS_EN to append a CRC-16-CCITT FCS after the last byte.
module hdlc_tx_framer #(
  parameter int OPEN_FLAGS = 1
) (
  input logic       Clk,
  input logic       Rst,
  hdlc_tx_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_OPEN_FLAG  = 3'd1,
    S_DATA       = 3'd2,
`ifdef HDLC_TX_FCS_EN
    S_FCS        = 3'd3,
`endif
    S_CLOSE_FLAG = 3'd4,
    S_ABORT      = 3'd5
  } state_t;

  // Patterns are indexed by transmission order, bit 0 goes out first.
  localparam logic [7:0] FLAG_PAT  = 8'h7E;
  localparam logic [7:0] ABORT_PAT = 8'hFE;
`ifdef HDLC_TX_FCS_EN
  localparam int SHIFT_W = 16;
`else
  localparam int SHIFT_W = 8;
`endif

  state_t               state_q, state_d;
  logic                 tx_q, tx_d, busy_q, busy_d, ready_q, ready_d;
  logic                 done_q, done_d, aborted_q, aborted_d, underrun_q, underrun_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic [1:0]           flag_cnt_q, flag_cnt_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic [4:0]           bit_cnt_q, bit_cnt_d;
  logic [2:0]           ones_q, ones_d;
  logic [7:0]           hold_q, hold_d;
  logic                 hold_full_q, hold_full_d, hold_last_q, hold_last_d;
  logic                 last_acc_q, last_acc_d, last_sent_q, last_sent_d;
  logic                 emit_s, bit_s, crc_upd_s, go_abort_s, go_close_s;
`ifdef HDLC_TX_FCS_EN
  logic [15:0]          crc_q, crc_d;

  function automatic logic [15:0] crc_next(input logic [15:0] crc, input logic b);
    crc_next = {1'b0, crc[15:1]} ^ (((crc[0] ^ b) == 1'b1) ? 16'h8408 : 16'h0000);
  endfunction
`endif

  // State and datapath registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      underrun_q  <= 1'b0;
      bit_idx_q   <= 4'd0;
      flag_cnt_q  <= 2'd0;
      shift_q     <= '0;
      bit_cnt_q   <= 5'd0;
      ones_q      <= 3'd0;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      hold_last_q <= 1'b0;
      last_acc_q  <= 1'b0;
      last_sent_q <= 1'b0;
`ifdef HDLC_TX_FCS_EN
      crc_q       <= 16'hFFFF;
`endif
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      underrun_q  <= underrun_d;
      bit_idx_q   <= bit_idx_d;
      flag_cnt_q  <= flag_cnt_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      ones_q      <= ones_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      hold_last_q <= hold_last_d;
      last_acc_q  <= last_acc_d;
      last_sent_q <= last_sent_d;
`ifdef HDLC_TX_FCS_EN
      crc_q       <= crc_d;
`endif
    end
  end

  // Next-state logic: each state decides the bit that goes on the line at the coming edge.
  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    underrun_d  = 1'b0;
    bit_idx_d   = bit_idx_q;
    flag_cnt_d  = flag_cnt_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    ones_d      = ones_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    hold_last_d = hold_last_q;
    last_acc_d  = last_acc_q;
    last_sent_d = last_sent_q;
    emit_s      = 1'b0;
    bit_s       = 1'b0;
    crc_upd_s   = 1'b0;
    go_abort_s  = 1'b0;
    go_close_s  = 1'b0;
`ifdef HDLC_TX_FCS_EN
    crc_d       = crc_q;
`endif

    if (bus.Tx_DataValid && ready_q) begin
      hold_d      = bus.Tx_Data;
      hold_full_d = 1'b1;
      hold_last_d = bus.Tx_Last;
      last_acc_d  = last_acc_q | bus.Tx_Last;
    end else begin
      hold_full_d = hold_full_q;
    end

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.Tx_Start) begin
          state_d     = S_OPEN_FLAG;
          tx_d        = FLAG_PAT[0];
          busy_d      = 1'b1;
          bit_idx_d   = 4'd1;
          flag_cnt_d  = 2'd0;
          hold_full_d = 1'b0;
          last_acc_d  = 1'b0;
          last_sent_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OPEN_FLAG: begin
        if (bus.Tx_AbortFrame) begin
          go_abort_s = 1'b1;
        end else begin
          tx_d = FLAG_PAT[bit_idx_q[2:0]];
          if (bit_idx_q == 4'd7) begin
            bit_idx_d = 4'd0;
            if (flag_cnt_q == 2'(OPEN_FLAGS - 1)) begin
              state_d   = S_DATA;
              bit_cnt_d = 5'd0;
              ones_d    = 3'd0;
`ifdef HDLC_TX_FCS_EN
              crc_d     = 16'hFFFF;
`endif
            end else begin
              flag_cnt_d = flag_cnt_q + 2'd1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (bus.Tx_AbortFrame) begin
          go_abort_s = 1'b1;
        end else if (ones_q == 3'd5) begin
          tx_d   = 1'b0;
          ones_d = 3'd0;
        end else if (bit_cnt_q == 5'd0) begin
          if (last_sent_q) begin
`ifdef HDLC_TX_FCS_EN
            state_d   = S_FCS;
            emit_s    = 1'b1;
            bit_s     = ~crc_q[0];
            shift_d   = SHIFT_W'((~crc_q) >> 1);
            bit_cnt_d = 5'd15;
`else
            go_close_s = 1'b1;
`endif
          end else if (hold_full_q) begin
            emit_s      = 1'b1;
            crc_upd_s   = 1'b1;
            bit_s       = hold_q[0];
            shift_d     = SHIFT_W'(hold_q >> 1);
            bit_cnt_d   = 5'd7;
            hold_full_d = 1'b0;
            last_sent_d = hold_last_q;
          end else begin
            underrun_d = 1'b1;
            go_abort_s = 1'b1;
          end
        end else begin
          emit_s    = 1'b1;
          crc_upd_s = 1'b1;
          bit_s     = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q - 5'd1;
        end
      end
`ifdef HDLC_TX_FCS_EN
      S_FCS: begin
        if (bus.Tx_AbortFrame) begin
          go_abort_s = 1'b1;
        end else if (ones_q == 3'd5) begin
          tx_d   = 1'b0;
          ones_d = 3'd0;
        end else if (bit_cnt_q == 5'd0) begin
          go_close_s = 1'b1;
        end else begin
          emit_s    = 1'b1;
          bit_s     = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q - 5'd1;
        end
      end
`endif
      S_CLOSE_FLAG: begin
        if (bit_idx_q == 4'd8) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          tx_d      = FLAG_PAT[bit_idx_q[2:0]];
          bit_idx_d = bit_idx_q + 4'd1;
        end
      end
      S_ABORT: begin
        if (bit_idx_q == 4'd8) begin
          state_d   = S_IDLE;
          tx_d      = 1'b1;
          busy_d    = 1'b0;
          aborted_d = 1'b1;
        end else begin
          tx_d      = ABORT_PAT[bit_idx_q[2:0]];
          bit_idx_d = bit_idx_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    if (emit_s) begin
      tx_d   = bit_s;
      ones_d = bit_s ? (ones_q + 3'd1) : 3'd0;
    end else begin
      ones_d = ones_d;
    end
`ifdef HDLC_TX_FCS_EN
    if (crc_upd_s) begin
      crc_d = crc_next(crc_q, bit_s);
    end else begin
      crc_d = crc_d;
    end
`endif
    if (go_close_s) begin
      state_d   = S_CLOSE_FLAG;
      tx_d      = FLAG_PAT[0];
      bit_idx_d = 4'd1;
    end else if (go_abort_s) begin
      // Abort drops the remaining bits, any pending stuffed zero and the prefetched byte.
      state_d     = S_ABORT;
      tx_d        = ABORT_PAT[0];
      bit_idx_d   = 4'd1;
      hold_full_d = 1'b0;
      hold_last_d = 1'b0;
    end else begin
      state_d = state_d;
    end

    ready_d = busy_d && !hold_full_d && !last_acc_d &&
              ((state_d == S_OPEN_FLAG) || (state_d == S_DATA));
  end

  assign bus.Tx              = tx_q;
  assign bus.Tx_Busy         = busy_q;
  assign bus.Tx_DataReady    = ready_q;
  assign bus.Tx_Done         = done_q;
  assign bus.Tx_AbortedTrans = aborted_q;
  assign bus.Tx_Underrun     = underrun_q;

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// Directed, table-driven bench for hdlc_tx_framer (OPEN_FLAGS=1); expected serial streams are hand-computed.
// Build with HDLC_TX_FCS_EN defined to run the FCS frame instead of the plain-frame table.
module tb_hdlc_tx_framer;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  hdlc_tx_if bus();

  hdlc_tx_framer #(.OPEN_FLAGS(1)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  typedef struct {
    int           n;
    logic [71:0]  bytes;
    logic         last_en;
    int           abort_at;
    int           exp_len;
    logic [127:0] exp_bits;
    logic         exp_abort;
    int           exp_under;
  } vec_t;

  vec_t       vecs[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] feed_q [0:8];
  int         feed_n = 0;
  int         feed_idx = 0;
  logic       feed_last_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_feed();
    bus.Tx_DataValid = (feed_idx < feed_n);
    bus.Tx_Data      = (feed_idx < feed_n) ? feed_q[feed_idx] : 8'h00;
    bus.Tx_Last      = feed_last_en && (feed_idx == feed_n - 1);
  endtask

  // One clock: record whether a byte transfers at the coming edge, then resample at the negedge.
  task automatic tick();
    logic x;
    x = bus.Tx_DataValid && bus.Tx_DataReady;
    @(negedge Clk);
    if (x) feed_idx++;
    drive_feed();
  endtask

  task automatic load_feed(input int n, input logic [71:0] bytes, input logic last_en);
    for (int i = 0; i < 9; i++) feed_q[i] = bytes[8*i +: 8];
    feed_n       = n;
    feed_idx     = 0;
    feed_last_en = last_en;
    drive_feed();
  endtask

  function automatic vec_t mk(input int n, input logic [71:0] bytes, input logic last_en,
                              input int abort_at, input int exp_len, input logic [127:0] exp_bits,
                              input logic exp_abort, input int exp_under);
    vec_t v;
    v.n = n; v.bytes = bytes; v.last_en = last_en; v.abort_at = abort_at;
    v.exp_len = exp_len; v.exp_bits = exp_bits; v.exp_abort = exp_abort; v.exp_under = exp_under;
    return v;
  endfunction

  task automatic run_frame(input vec_t v, input int vi);
    logic [127:0] cap;
    int           end_c, un_at;
    logic         end_done, end_ab, end_tx, end_busy;
    cap = '0; end_c = 0; un_at = 0;
    end_done = 1'b0; end_ab = 1'b0; end_tx = 1'b0; end_busy = 1'b1;
    load_feed(v.n, v.bytes, v.last_en);
    bus.Tx_Start = 1'b1;
    for (int c = 1; c <= 150; c++) begin
      tick();
      bus.Tx_Start      = 1'b0;
      bus.Tx_AbortFrame = (c == v.abort_at);
      if (bus.Tx_Underrun && un_at == 0) un_at = c;
      if (bus.Tx_Done || bus.Tx_AbortedTrans) begin
        end_c = c; end_done = bus.Tx_Done; end_ab = bus.Tx_AbortedTrans;
        end_tx = bus.Tx; end_busy = bus.Tx_Busy;
        break;
      end
      cap = {cap[126:0], bus.Tx};
    end
    bus.Tx_AbortFrame = 1'b0;
    check($sformatf("v%0d_len", vi), 128'(end_c - 1), 128'(v.exp_len));
    check($sformatf("v%0d_bits", vi), cap, v.exp_bits);
    check($sformatf("v%0d_end_kind", vi), {126'd0, end_done, end_ab},
          v.exp_abort ? 128'd1 : 128'd2);
    check($sformatf("v%0d_end_line", vi), {126'd0, end_tx, end_busy}, 128'd2);
    check($sformatf("v%0d_underrun_at", vi), 128'(un_at), 128'(v.exp_under));
    tick();
    check($sformatf("v%0d_after", vi),
          {124'd0, bus.Tx_Done, bus.Tx_AbortedTrans, bus.Tx, bus.Tx_Busy}, 128'd2);
  endtask

  initial begin
    int d, ab, un;
    Rst = 1'b1;
    bus.Tx_Start = 1'b0; bus.Tx_AbortFrame = 1'b0;
    load_feed(0, 72'd0, 1'b0);
`ifdef HDLC_TX_FCS_EN
    vecs.push_back(mk(9, 72'h39_38_37_36_35_34_33_32_31, 1'b1, 0, 104,
      128'b01111110_10001100_01001100_11001100_00101100_10101100_01101100_11101100_00011100_10011100_01110110_00001001_01111110,
      1'b0, 0));
`else
    vecs.push_back(mk(2, 72'h02_01, 1'b1, 0, 32, 128'b01111110_10000000_01000000_01111110, 1'b0, 0));
    vecs.push_back(mk(1, 72'hFF, 1'b1, 0, 25, 128'b01111110_111110111_01111110, 1'b0, 0));
    vecs.push_back(mk(1, 72'h00, 1'b1, 0, 24, 128'b01111110_00000000_01111110, 1'b0, 0));
    vecs.push_back(mk(3, 72'h33_55_AA, 1'b1, 19, 27, 128'b01111110_01010101_101_01111111, 1'b1, 0));
    vecs.push_back(mk(1, 72'h7E, 1'b0, 0, 25, 128'b01111110_011111010_01111111, 1'b1, 18));
    vecs.push_back(mk(1, 72'hF8, 1'b1, 0, 25, 128'b01111110_000111110_01111110, 1'b0, 0));
    vecs.push_back(mk(2, 72'hFF_FF, 1'b1, 0, 35, 128'b01111110_1111101111101111101_01111110, 1'b0, 0));
`endif

    @(negedge Clk); @(negedge Clk);
    check("reset_outputs", {122'd0, bus.Tx, bus.Tx_Busy, bus.Tx_DataReady, bus.Tx_Done,
                            bus.Tx_AbortedTrans, bus.Tx_Underrun}, 128'h20);
    Rst = 1'b0;
    tick();
    check("idle_line", {126'd0, bus.Tx, bus.Tx_Busy}, 128'd2);

    for (int i = 0; i < vecs.size(); i++) run_frame(vecs[i], i);

    // Reset between edges in the middle of the data phase.
    load_feed(vecs[0].n, vecs[0].bytes, vecs[0].last_en);
    bus.Tx_Start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      bus.Tx_Start = 1'b0;
    end
    #2 Rst = 1'b1;
    #1 check("async_reset", {125'd0, bus.Tx, bus.Tx_Busy, bus.Tx_DataReady}, 128'd4);
    load_feed(0, 72'd0, 1'b0);
    @(negedge Clk);
    Rst = 1'b0;
    tick();
    run_frame(vecs[0], 100);

    // Tx_Start held high: ignored while busy, then restarts from the Done cycle.
    load_feed(1, 72'h00, 1'b1);
    bus.Tx_Start = 1'b1;
    d = 0;
    for (int c = 1; c <= 150; c++) begin
      tick();
      if (bus.Tx_Done) begin
        d = c;
        break;
      end
    end
    check("hold_start_done_seen", 128'(d > 0), 128'd1);
    tick();
    bus.Tx_Start = 1'b0;
    check("restart_from_done", {126'd0, bus.Tx, bus.Tx_Busy}, 128'd1);
    ab = 0; un = 0; d = 0;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (bus.Tx_Underrun) un = 1;
      if (bus.Tx_Done) d = 1;
      if (bus.Tx_AbortedTrans) begin
        ab = 1;
        break;
      end
    end
    check("restart_empty_underrun", {125'd0, 1'(un), 1'(ab), 1'(d)}, 128'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
